uart_tx_fifo: RTL and testbench

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

---
 rtl/uart_tx_fifo.sv | 199 +++++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// UART transmitter with a configurable frame format and a transmit FIFO.
// The frame format is captured at the start bit, so a frame is never altered mid-flight.
module uart_tx_fifo #(
  parameter int MAX_WORD   = 9,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic [7:0]                    i_config,
  input  logic [MAX_WORD-1:0]           i_tx_parallel,
  input  logic                          i_tx_valid,
  output logic                          o_tx_ready,
  input  logic                          i_uart_clk_enable,
  output logic                          o_tx,
  output logic                          o_busy,
  output logic [$clog2(FIFO_DEPTH):0]   o_fifo_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [3:0]    RST_WS  = (MAX_WORD < 8) ? 4'(MAX_WORD) : 4'd8;
  localparam logic [3:0]    MAX_WS  = 4'(MAX_WORD);
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;
  localparam logic [1:0] PAR_MARK = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

  logic [MAX_WORD-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]       r_wr_ptr;
  logic [AW-1:0]       r_rd_ptr;
  logic [CW-1:0]       r_count;
  logic [CW-1:0]       w_count_next;
  logic                r_ready;

  logic [3:0]          r_cfg_ws;
  logic [1:0]          r_cfg_par;
  logic                r_cfg_stop2;
  logic [3:0]          w_cfg_ws;
  logic                w_cfg_store;

  state_t              r_state;
  state_t              w_state_next;
  logic [MAX_WORD-1:0] r_shift;
  logic [MAX_WORD-1:0] w_shift_next;
  logic [3:0]          r_bit_cnt;
  logic [3:0]          w_bit_cnt_next;
  logic                r_tx;
  logic                w_tx_next;
  logic [3:0]          r_frame_ws;
  logic                r_frame_par_en;
  logic                r_frame_stop2;
  logic                r_par_bit;
  logic                w_par_bit;

  logic                w_push;
  logic                w_pop;
  logic [MAX_WORD-1:0] w_mask;
  logic [MAX_WORD-1:0] w_head;

  // Bits at or above the stored word size are cleared on the way into the FIFO.
  for (genvar gi = 0; gi < MAX_WORD; gi++) begin : g_mask
    assign w_mask[gi] = (4'(gi) < r_cfg_ws);
  end

  assign w_head      = r_mem[r_rd_ptr];
  assign w_push      = i_tx_valid && r_ready;
  assign w_cfg_store = i_config[0] && (r_state == S_IDLE) && (r_count == '0);

  assign o_tx         = r_tx;
  assign o_busy       = (r_state != S_IDLE);
  assign o_fifo_count = r_count;
  assign o_tx_ready   = r_ready;

  always_comb begin
    w_cfg_ws = i_config[4:1];
    if (i_config[4:1] < 4'd5) begin
      w_cfg_ws = 4'd5;
    end else if (i_config[4:1] > MAX_WS) begin
      w_cfg_ws = MAX_WS;
    end
  end

  always_comb begin
    w_par_bit = 1'b0;
    unique case (r_cfg_par)
      PAR_EVEN: w_par_bit = ^w_head;
      PAR_ODD:  w_par_bit = ~^w_head;
      PAR_MARK: w_par_bit = 1'b1;
      default:  w_par_bit = 1'b0;
    endcase
  end

  always_comb begin
    w_state_next   = r_state;
    w_shift_next   = r_shift;
    w_bit_cnt_next = r_bit_cnt;
    w_tx_next      = r_tx;
    w_pop          = 1'b0;
    if (i_uart_clk_enable) begin
      unique case (r_state)
        S_IDLE: begin
          w_tx_next = 1'b1;
          if (r_count != '0) begin
            w_pop          = 1'b1;
            w_tx_next      = 1'b0;
            w_shift_next   = w_head;
            w_bit_cnt_next = '0;
            w_state_next   = S_DATA;
          end
        end
        S_DATA: begin
          w_tx_next      = r_shift[0];
          w_shift_next   = r_shift >> 1;
          w_bit_cnt_next = r_bit_cnt + 4'd1;
          if (r_bit_cnt == r_frame_ws - 4'd1) begin
            w_bit_cnt_next = '0;
            w_state_next   = r_frame_par_en ? S_PARITY : S_STOP;
          end
        end
        S_PARITY: begin
          w_tx_next    = r_par_bit;
          w_state_next = S_STOP;
        end
        S_STOP: begin
          // The bit counter doubles as the stop-bit counter here.
          w_tx_next      = 1'b1;
          w_bit_cnt_next = r_bit_cnt + 4'd1;
          if (r_bit_cnt == {3'b000, r_frame_stop2}) begin
            w_bit_cnt_next = '0;
            w_state_next   = S_IDLE;
          end
        end
        default: w_state_next = S_IDLE;
      endcase
    end
  end

  always_comb begin
    w_count_next = r_count;
    unique case ({w_push, w_pop})
      2'b10:   w_count_next = r_count + CW'(1);
      2'b01:   w_count_next = r_count - CW'(1);
      default: w_count_next = r_count;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state        <= S_IDLE;
      r_tx           <= 1'b1;
      r_shift        <= '0;
      r_bit_cnt      <= '0;
      r_wr_ptr       <= '0;
      r_rd_ptr       <= '0;
      r_count        <= '0;
      r_ready        <= 1'b0;
      r_cfg_ws       <= RST_WS;
      r_cfg_par      <= PAR_NONE;
      r_cfg_stop2    <= 1'b0;
      r_frame_ws     <= RST_WS;
      r_frame_par_en <= 1'b0;
      r_frame_stop2  <= 1'b0;
      r_par_bit      <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_tx      <= w_tx_next;
      r_shift   <= w_shift_next;
      r_bit_cnt <= w_bit_cnt_next;
      r_count   <= w_count_next;
      r_ready   <= (w_count_next != DEPTH_C);
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr       <= r_rd_ptr + AW'(1);
        r_frame_ws     <= r_cfg_ws;
        r_frame_par_en <= (r_cfg_par != PAR_NONE);
        r_frame_stop2  <= r_cfg_stop2;
        r_par_bit      <= w_par_bit;
      end
      if (w_cfg_store) begin
        r_cfg_ws    <= w_cfg_ws;
        r_cfg_par   <= i_config[6:5];
        r_cfg_stop2 <= i_config[7];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_tx_parallel & w_mask;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: directed frame table, FIFO/config/reset
// corner sequences, and a randomized run against a queue-based line model.
module tb_uart_tx_fifo;

  localparam int MW    = 9;
  localparam int DEPTH = 4;

  logic        clk;
  logic        rst;
  logic [7:0]  cfg;
  logic [8:0]  data;
  logic        valid;
  logic        en;
  logic        tx_ready;
  logic        tx;
  logic        busy;
  logic [2:0]  fifo_count;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: stored words, remaining bits of the frame on the line, config.
  int unsigned m_q[$];
  int          m_line[$];
  int          m_tx    = 1;
  int          m_ready = 0;
  int          m_ws    = 8;
  int          m_par   = 0;
  int          m_stop  = 1;

  uart_tx_fifo #(.MAX_WORD(MW), .FIFO_DEPTH(DEPTH)) dut (
    .i_clk             (clk),
    .i_rst             (rst),
    .i_config          (cfg),
    .i_tx_parallel     (data),
    .i_tx_valid        (valid),
    .o_tx_ready        (tx_ready),
    .i_uart_clk_enable (en),
    .o_tx              (tx),
    .o_busy            (busy),
    .o_fifo_count      (fifo_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_edge(input logic a_rst, input logic [7:0] a_cfg,
                            input logic [8:0] a_data, input logic a_valid, input logic a_en);
    int  cnt;
    int  w;
    int  p;
    int  n;
    bit  was_busy;
    bit  do_push;
    bit  do_store;
    if (a_rst) begin
      m_q.delete();
      m_line.delete();
      m_tx = 1; m_ready = 0; m_ws = 8; m_par = 0; m_stop = 1;
      return;
    end
    was_busy = (m_line.size() != 0);
    cnt      = m_q.size();
    do_push  = a_valid && (m_ready != 0);
    do_store = a_cfg[0] && !was_busy && (cnt == 0);
    if (a_en) begin
      if (was_busy) begin
        m_tx = m_line.pop_front();
      end else if (cnt > 0) begin
        w = int'(m_q.pop_front());
        for (int b = 0; b < m_ws; b++) m_line.push_back((w >> b) & 1);
        p = $countones(w) & 1;
        if (m_par == 1) m_line.push_back(p);
        else if (m_par == 2) m_line.push_back(1 - p);
        else if (m_par == 3) m_line.push_back(1);
        for (int s = 0; s < m_stop; s++) m_line.push_back(1);
        m_tx = 0;
        $display("frame start word=%03h ws=%0d par=%0d stop=%0d", w, m_ws, m_par, m_stop);
      end else begin
        m_tx = 1;
      end
    end
    if (do_push) m_q.push_back(int'(a_data) & ((1 << m_ws) - 1));
    if (do_store) begin
      n = int'(a_cfg[4:1]);
      m_ws   = (n < 5) ? 5 : ((n > MW) ? MW : n);
      m_par  = int'(a_cfg[6:5]);
      m_stop = a_cfg[7] ? 2 : 1;
    end
    m_ready = (m_q.size() != DEPTH) ? 1 : 0;
  endtask

  // One clock: drive inputs, let the edge happen, advance the model, compare all outputs.
  task automatic cycle(input logic a_rst, input logic [7:0] a_cfg, input logic [8:0] a_data,
                       input logic a_valid, input logic a_en);
    rst = a_rst; cfg = a_cfg; data = a_data; valid = a_valid; en = a_en;
    @(posedge clk);
    model_edge(a_rst, a_cfg, a_data, a_valid, a_en);
    #1;
    check("tx", int'(tx), m_tx);
    check("busy", int'(busy), (m_line.size() != 0) ? 1 : 0);
    check("count", int'(fifo_count), m_q.size());
    check("ready", int'(tx_ready), m_ready);
  endtask

  task automatic do_reset();
    cycle(1'b1, 8'h00, 9'h000, 1'b0, 1'b0);
    cycle(1'b1, 8'h00, 9'h000, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 9'h000, 1'b0, 1'b0);
  endtask

  // Enables every third clock until a frame has started and completed.
  task automatic run_frame(input logic [7:0] mid_cfg, output int len);
    bit seen;
    bit done;
    len  = 0;
    seen = 0;
    done = 0;
    for (int k = 0; k < 200 && !done; k++) begin
      cycle(1'b0, (k == 3) ? mid_cfg : 8'h00, 9'h000, 1'b0, (k % 3) == 2);
      if ((k % 3) == 2) len++;
      if (busy) seen = 1;
      if (seen && !busy) done = 1;
    end
    check("frame_completed", int'(done), 1);
  endtask

  typedef struct {
    logic [7:0] cfg;
    logic [8:0] word;
    int         nbits;
    int         bits;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int   got;
    int   collected;
    int   len;
    logic s [64];
    int   ns;
    int   word;
    int   exp_words[4];
    logic [7:0] rc;
    logic       rv;
    logic       re;

    rst = 1'b1; cfg = 8'h00; data = 9'h000; valid = 1'b0; en = 1'b0;

    // {config strobe word, data word, frame length, line bits in order (bit i = i-th enable)}
    vecs[0] = '{8'h00, 9'h0A5, 10, 32'h0000_034A};  // default 8N1
    vecs[1] = '{8'hAF, 9'h1FF, 11, 32'h0000_07FE};  // 7 bits, even, two stops
    vecs[2] = '{8'h5F, 9'h000, 12, 32'h0000_0C00};  // size 15 clamps to 9, odd
    vecs[3] = '{8'h65, 9'h1FF,  8, 32'h0000_00FE};  // size 2 clamps to 5, mark
    vecs[4] = '{8'h13, 9'h155, 11, 32'h0000_06AA};  // 9 bits, no parity
    vecs[5] = '{8'h4D, 9'h02D,  9, 32'h0000_01DA};  // 6 bits, odd

    cycle(1'b1, 8'h00, 9'h000, 1'b0, 1'b0);
    check("reset_tx", int'(tx), 1);
    check("reset_busy", int'(busy), 0);
    check("reset_count", int'(fifo_count), 0);
    check("reset_ready", int'(tx_ready), 0);
    cycle(1'b0, 8'h00, 9'h000, 1'b0, 1'b0);
    check("ready_after_reset", int'(tx_ready), 1);

    for (int v = 0; v < 6; v++) begin
      do_reset();
      if (vecs[v].cfg[0]) cycle(1'b0, vecs[v].cfg, 9'h000, 1'b0, 1'b0);
      cycle(1'b0, 8'h00, vecs[v].word, 1'b1, 1'b0);
      check($sformatf("vec%0d_count_before", v), int'(fifo_count), 1);
      got = 0;
      collected = 0;
      for (int k = 0; k < (vecs[v].nbits + 1) * 4 + 8 && collected < vecs[v].nbits + 1; k++) begin
        cycle(1'b0, 8'h00, 9'h000, 1'b0, (k % 4) == 3);
        if ((k % 4) == 3) begin
          if (collected == 0) check($sformatf("vec%0d_count_at_start", v), int'(fifo_count), 0);
          if (collected < vecs[v].nbits) got = got | (int'(tx) << collected);
          else check($sformatf("vec%0d_idle_after", v), int'(tx), 1);
          collected++;
        end
      end
      check($sformatf("vec%0d_enables", v), collected, vecs[v].nbits + 1);
      check($sformatf("vec%0d_bits", v), got, vecs[v].bits);
      $display("vec%0d cfg=%02h word=%03h line=%0h", v, vecs[v].cfg, vecs[v].word, got);
    end

    // FIFO full: the fifth push is dropped, the first four drain in order.
    do_reset();
    exp_words = '{32'h11, 32'h22, 32'h33, 32'h44};
    for (int i = 0; i < 5; i++) cycle(1'b0, 8'h00, 9'(8'h11 * (i + 1)), 1'b1, 1'b0);
    check("full_ready", int'(tx_ready), 0);
    check("full_count", int'(fifo_count), 4);
    ns = 0;
    for (int k = 0; k < 88; k++) begin
      cycle(1'b0, 8'h00, 9'h000, 1'b0, (k % 2) == 1);
      if ((k % 2) == 1) begin
        s[ns] = tx;
        ns++;
      end
    end
    for (int f = 0; f < 4; f++) begin
      word = 0;
      for (int b = 0; b < 8; b++) word = word | (int'(s[f * 10 + 1 + b]) << b);
      check($sformatf("drain%0d_start", f), int'(s[f * 10]), 0);
      check($sformatf("drain%0d_word", f), word, exp_words[f]);
      check($sformatf("drain%0d_stop", f), int'(s[f * 10 + 9]), 1);
      $display("drain frame %0d word=%02h", f, word);
    end
    for (int i = 40; i < 44; i++) check("drain_idle", int'(s[i]), 1);

    // Config strobes while busy or non-empty are ignored; idle-and-empty takes effect.
    do_reset();
    cycle(1'b0, 8'h00, 9'h03C, 1'b1, 1'b0);
    cycle(1'b0, 8'h0B, 9'h000, 1'b0, 1'b0);
    run_frame(8'h0B, len);
    check("cfg_busy_ignored_len", len, 10);
    cycle(1'b0, 8'h0B, 9'h000, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 9'h03C, 1'b1, 1'b0);
    run_frame(8'h00, len);
    check("cfg_idle_taken_len", len, 7);
    $display("config strobe sequence done");

    // Reset in the middle of DATA with a second word queued.
    do_reset();
    cycle(1'b0, 8'h00, 9'h0A5, 1'b1, 1'b0);
    cycle(1'b0, 8'h00, 9'h05A, 1'b1, 1'b0);
    cycle(1'b0, 8'h00, 9'h000, 1'b0, 1'b1);
    cycle(1'b0, 8'h00, 9'h000, 1'b0, 1'b1);
    cycle(1'b0, 8'h00, 9'h000, 1'b0, 1'b1);
    check("mid_data_busy", int'(busy), 1);
    cycle(1'b1, 8'h00, 9'h000, 1'b0, 1'b1);
    check("abort_tx", int'(tx), 1);
    check("abort_count", int'(fifo_count), 0);
    check("abort_busy", int'(busy), 0);
    cycle(1'b0, 8'h00, 9'h000, 1'b0, 1'b1);
    check("abort_no_resume", int'(busy), 0);
    cycle(1'b0, 8'h00, 9'h0A5, 1'b1, 1'b0);
    run_frame(8'h00, len);
    check("after_abort_len", len, 10);
    $display("reset abort sequence done");

    // Randomized traffic against the model, alternating push-heavy and drain-heavy phases.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      rc = ($urandom_range(0, 39) == 0) ? (8'($urandom) | 8'h01) : 8'h00;
      rv = ($urandom_range(0, 15) < (((i % 1000) < 500) ? 8 : 1));
      re = ((i % 600) < 100) ? 1'b1 : ($urandom_range(0, 2) == 0);
      cycle($urandom_range(0, 699) == 0, rc, 9'($urandom), rv, re);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
